// File: rtl/prog_loader.sv
// prog_loader: fills instruction memory from a framed UART byte stream.
// Frame: 16-bit little-endian word count, then little-endian 32-bit words.
// Optional build macro PROG_LOADER_CHECKSUM_EN appends an 8-bit XOR check byte.
module prog_loader #(
  parameter int unsigned ADDR_W    = 14,
  parameter int unsigned MAX_WORDS = 4096,
  parameter int unsigned CNT_W     = 13
) (
  input  logic              clk_i,
  input  logic              rst_n,       // active-high synchronous reset
  input  logic              start_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [31:0]       wr_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              cpu_hold_o,
  output logic [CNT_W-1:0]  words_o
);

  typedef enum logic [2:0] {
    StIdle,
    StLenLo,
    StLenHi,
    StData,
`ifdef PROG_LOADER_CHECKSUM_EN
    StChk,
`endif
    StDone,
    StErr
  } state_e;

  state_e            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [31:0]       sh_q, sh_d;
  logic [1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]  words_q, words_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic              hold_q, hold_d;
  logic [15:0]       len_new;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]        xor_q, xor_d;
`endif

  assign len_new = {rx_data_i, len_q[7:0]};

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    sh_d      = sh_q;
    idx_d     = idx_q;
    words_d   = words_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    xor_d     = xor_q;
`endif
    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start_i) begin
          state_d = StLenLo;
          words_d = '0;
          idx_d   = 2'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
          xor_d   = 8'h00;
`endif
        end
      end
      StLenLo: begin
        if (rx_valid_i) begin
          len_d[7:0] = rx_data_i;
          state_d    = StLenHi;
        end
      end
      StLenHi: begin
        if (rx_valid_i) begin
          len_d[15:8] = rx_data_i;
          if (len_new == 16'd0 || 32'(len_new) > MAX_WORDS) state_d = StErr;
          else                                               state_d = StData;
        end
      end
      StData: begin
        if (rx_valid_i) begin
          // Little-endian: each new byte enters at the top and slides down.
          sh_d  = {rx_data_i, sh_q[31:8]};
          idx_d = idx_q + 2'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
          xor_d = xor_q ^ rx_data_i;
`endif
          if (idx_q == 2'd3) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ADDR_W'(words_q) << 2;
            wr_data_d = {rx_data_i, sh_q[31:8]};
            words_d   = words_q + CNT_W'(1);
            if ((32'(words_q) + 32'd1) == 32'(len_q)) begin
`ifdef PROG_LOADER_CHECKSUM_EN
              state_d = StChk;
`else
              state_d = StDone;
`endif
            end
          end
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      StChk: begin
        if (rx_valid_i) state_d = (rx_data_i == xor_q) ? StDone : StErr;
      end
`endif
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StLenLo) || (state_d == StLenHi) || (state_d == StData)
`ifdef PROG_LOADER_CHECKSUM_EN
             || (state_d == StChk)
`endif
             ;
    hold_d = busy_d || (state_d == StErr);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_n) begin
      state_q   <= StIdle;
      len_q     <= '0;
      sh_q      <= '0;
      idx_q     <= '0;
      words_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      hold_q    <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      xor_q     <= 8'h00;
`endif
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      sh_q      <= sh_d;
      idx_q     <= idx_d;
      words_q   <= words_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      hold_q    <= hold_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      xor_q     <= xor_d;
`endif
    end
  end

  assign wr_en_o    = wr_en_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = wr_data_q;
  assign busy_o     = busy_q;
  assign cpu_hold_o = hold_q;
  assign words_o    = words_q;
  assign done_o     = (state_q == StDone);
  assign err_o      = (state_q == StErr);

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader; reference model works on whole frames.
module tb_prog_loader;
  localparam int unsigned ADDR_W    = 14;
  localparam int unsigned MAX_WORDS = 4096;
  localparam int unsigned CNT_W     = 13;

  typedef logic [7:0] bq_t[$];

  logic              clk_i = 1'b0;
  logic              rst_n = 1'b1;
  logic              start_i = 1'b0;
  logic [7:0]        rx_data_i = 8'h00;
  logic              rx_valid_i = 1'b0;
  logic              wr_en_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [31:0]       wr_data_o;
  logic              busy_o, done_o, err_o, cpu_hold_o;
  logic [CNT_W-1:0]  words_o;

  prog_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_n(rst_n), .start_i(start_i), .rx_data_i(rx_data_i),
    .rx_valid_i(rx_valid_i), .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o),
    .wr_data_o(wr_data_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .cpu_hold_o(cpu_hold_o), .words_o(words_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Observed writes, stamped with the cycle they were visible in.
  logic [31:0] act_addr[$];
  logic [31:0] act_data[$];
  int          act_cyc[$];
  logic        prev_wen = 1'b0;
  // Bytes driven in the current session, with the cycle each was consumed.
  logic [7:0]  stim_b[$];
  int          stim_c[$];

  always @(negedge clk_i) begin
    if (wr_en_o) begin
      act_addr.push_back(32'(wr_addr_o));
      act_data.push_back(wr_data_o);
      act_cyc.push_back(cyc);
      checks++;
      assert (prev_wen === 1'b0) else begin
        errors++;
        $error("FAIL wr_en_single: got two consecutive strobes, required one");
      end
    end
    prev_wen = wr_en_o;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_obs();
    act_addr.delete(); act_data.delete(); act_cyc.delete();
    stim_b.delete(); stim_c.delete();
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    tick();
    stim_b.push_back(b);
    stim_c.push_back(cyc);
    rx_valid_i = 1'b0;
    rx_data_i  = 8'($urandom);
  endtask

  task automatic pulse_start();
    clear_obs();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("start_busy", 32'(busy_o), 32'd1);
    chk("start_hold", 32'(cpu_hold_o), 32'd1);
    chk("start_clr_err", 32'(err_o), 32'd0);
    chk("start_clr_done", 32'(done_o), 32'd0);
    chk("start_clr_words", 32'(words_o), 32'd0);
  endtask

  function automatic logic [7:0] xsum(input bq_t bs, input int from, input int n);
    logic [7:0] x = 8'h00;
    for (int i = from; i < from + n; i++) x = x ^ bs[i];
    return x;
  endfunction

  // Reference: decode the whole frame that was sent and compare the outcome.
  task automatic check_session(input string name);
    int  len = 0, nw = 0;
    logic exp_done = 1'b0, exp_err = 1'b0;
    if (stim_b.size() >= 2) len = int'(stim_b[0]) + 256 * int'(stim_b[1]);
    if (len == 0 || len > int'(MAX_WORDS)) exp_err = 1'b1;
    else begin
      nw = len;
`ifdef PROG_LOADER_CHECKSUM_EN
      if (stim_b[2 + 4*len] == xsum(stim_b, 2, 4*len)) exp_done = 1'b1;
      else                                             exp_err  = 1'b1;
`else
      exp_done = 1'b1;
`endif
    end
    chk({name, "_nwrites"}, 32'(act_addr.size()), 32'(nw));
    for (int k = 0; k < nw && k < act_addr.size(); k++) begin
      chk({name, "_addr"}, act_addr[k], 32'(4 * k));
      chk({name, "_data"}, act_data[k], {stim_b[2+4*k+3], stim_b[2+4*k+2],
                                          stim_b[2+4*k+1], stim_b[2+4*k]});
      chk({name, "_lat"}, 32'(act_cyc[k]), 32'(stim_c[2+4*k+3]));
    end
    chk({name, "_done"}, 32'(done_o), 32'(exp_done));
    chk({name, "_err"}, 32'(err_o), 32'(exp_err));
    chk({name, "_hold"}, 32'(cpu_hold_o), 32'(exp_err));
    chk({name, "_busy"}, 32'(busy_o), 32'd0);
    chk({name, "_words"}, 32'(words_o), 32'(nw));
    chk({name, "_wren"}, 32'(wr_en_o), 32'd0);
  endtask

  task automatic load(input string name, input bq_t bs, input int max_gap, input int start_at);
    pulse_start();
    foreach (bs[i]) begin
      if (i == start_at) start_i = 1'b1;
      send(bs[i]);
      start_i = 1'b0;
      repeat ($urandom_range(max_gap, 0)) tick();
    end
    repeat (3) tick();
    check_session(name);
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_wren"}, 32'(wr_en_o), 32'd0);
    chk({name, "_addr"}, 32'(wr_addr_o), 32'd0);
    chk({name, "_data"}, wr_data_o, 32'd0);
    chk({name, "_busy"}, 32'(busy_o), 32'd0);
    chk({name, "_done"}, 32'(done_o), 32'd0);
    chk({name, "_err"}, 32'(err_o), 32'd0);
    chk({name, "_hold"}, 32'(cpu_hold_o), 32'd0);
    chk({name, "_words"}, 32'(words_o), 32'd0);
  endtask

  initial begin
    bq_t basic, q;
    basic = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef PROG_LOADER_CHECKSUM_EN
    basic.push_back(xsum(basic, 2, 8));
`endif

    // Reset state.
    repeat (2) tick();
    rst_n = 1'b0;
    check_all_zero("reset");

    // Bytes in IDLE are ignored.
    clear_obs();
    for (int i = 0; i < 6; i++) send(8'($urandom));
    repeat (2) tick();
    chk("idle_nwrites", 32'(act_addr.size()), 32'd0);
    chk("idle_busy", 32'(busy_o), 32'd0);
    chk("idle_words", 32'(words_o), 32'd0);

    // Basic back-to-back load, with explicit expected words.
    load("basic", basic, 0, -1);
    if (act_data.size() == 2) begin
      chk("basic_w0", act_data[0], 32'h12345678);
      chk("basic_w1", act_data[1], 32'hDEADBEEF);
      chk("basic_a1", act_addr[1], 32'h4);
    end else chk("basic_cnt", 32'(act_data.size()), 32'd2);

    // Same frame with idle gaps.
    load("gapped", basic, 5, -1);

    // Bad length headers.
    q = '{8'h00, 8'h00};
    load("len0", q, 2, -1);
    q = '{8'h01, 8'h10};
    load("len4097", q, 2, -1);
    pulse_start();  // clears err_o
    repeat (2) tick();

    // Reset mid-load: one full word plus two bytes.
    pulse_start();
    q = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    foreach (q[i]) send(q[i]);
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    check_all_zero("midrst");
    repeat (3) tick();
    chk("midrst_nwrites", 32'(act_addr.size()), 32'd1);
    load("after_rst", basic, 1, -1);

    // start_i during DATA does not restart.
    load("start_in_data", basic, 0, 5);

    // Randomised frames.
    for (int it = 0; it < 10; it++) begin
      int n = $urandom_range(6, 1);
      q = '{};
      q.push_back(8'(n));
      q.push_back(8'h00);
      for (int i = 0; i < 4 * n; i++) q.push_back(8'($urandom));
`ifdef PROG_LOADER_CHECKSUM_EN
      if ($urandom_range(1, 0) == 1) q.push_back(xsum(q, 2, 4 * n));
      else q.push_back(xsum(q, 2, 4 * n) ^ 8'(1 << $urandom_range(7, 0)));
`else
      if ($urandom_range(1, 0) == 1) q.push_back(8'($urandom));  // trailing junk
`endif
      load("random", q, 3, -1);
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    q = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0F};
    load("chk_good", q, 0, -1);
    chk("chk_good_done", 32'(done_o), 32'd1);
    q = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0E};
    load("chk_bad", q, 0, -1);
    chk("chk_bad_err", 32'(err_o), 32'd1);
    chk("chk_bad_nwrites", 32'(act_addr.size()), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the instruction-memory path. The fetch unit reads the program ROM/RAM; this block fills it.
- Consumes a byte stream (from the UART receiver) framed as a length header followed by little-endian 32-bit words.
- Issues one-cycle word writes to the instruction memory port at byte addresses 0, 4, 8, ..., matching the fetch unit's PC stepping.
- Holds the CPU off (cpu_hold_o) while loading, and after a failed load.

Parameters:
ADDR_W, 14, byte-address width of instruction memory; same as the fetch unit's PC width
MAX_WORDS, 4096, largest accepted word count; must be ≤ 2^(ADDR_W-2)
CNT_W, 13, word-count register width; must hold MAX_WORDS

Ports:
clk_i  in  1  system clock; all logic on posedge
rst_n  in  1  reset; synchronous, active-high (despite the name)
start_i  in  1  one-cycle pulse; begins a load session
rx_data_i  in  8  received byte
rx_valid_i  in  1  rx_data_i valid this cycle; every valid cycle is consumed, no backpressure
wr_en_o  out  1  instruction memory write strobe, one cycle per word
wr_addr_o  out  ADDR_W  byte address of write; bits [1:0] always 0
wr_data_o  out  32  word to write
busy_o  out  1  load in progress
done_o  out  1  load completed successfully; held
err_o  out  1  load failed; held
cpu_hold_o  out  1  hold CPU in reset / stall fetch
words_o  out  CNT_W  words written so far in current session

Behaviour:
- Reset (rst_n=1 at posedge):
  - state=IDLE.
  - All outputs 0: wr_en_o, wr_addr_o, wr_data_o, busy_o, done_o, err_o, cpu_hold_o, words_o.
  - Byte index, length and shift register cleared.
  - Reset mid-session discards any partial word and aborts with no further writes.
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, CHK (only with the optional feature), DONE, ERR.
- IDLE / DONE / ERR:
  - start_i=1 → LEN_LO; clear done_o, err_o, words_o and the byte index.
  - rx_valid_i is ignored in these states.
- start_i is ignored while in LEN_LO, LEN_HI, DATA or CHK.
- Busy states:
  - busy_o=1 and cpu_hold_o=1 in LEN_LO, LEN_HI, DATA, CHK; both are registered, so they rise the cycle after start_i.
  - cpu_hold_o stays 1 in ERR and is 0 in IDLE and DONE.
- LEN_LO: on a valid byte, len[7:0]=byte → LEN_HI.
- LEN_HI: on a valid byte, len[15:8]=byte, then evaluate the length:
  - length 0 → ERR.
  - length > MAX_WORDS → ERR.
  - otherwise → DATA.
- DATA:
  - Each valid byte shifts in little-endian: the first byte of a word goes to [7:0], the fourth to [31:24].
  - A 2-bit byte index wraps 3→0.
  - On the 4th byte, in the next cycle:
    - wr_en_o=1 for exactly one cycle.
    - wr_addr_o = words_o*4, using the pre-increment value.
    - wr_data_o = the assembled word.
    - words_o increments in that same cycle.
  - Write latency is 1 cycle after the 4th byte's valid cycle.
  - Bytes may arrive back-to-back every cycle, including in the write cycle; none are dropped.
  - After the last word's 4th byte:
    - without CHECKSUM_EN → DONE;
    - with CHECKSUM_EN → CHK.
  - The final write strobe still occurs in the first cycle of DONE/CHK.
- DONE: done_o=1, held until the next start_i or reset.
- ERR: err_o=1, held until the next start_i or reset; no further writes.
- wr_addr_o and wr_data_o hold their last values when wr_en_o=0.
- Address arithmetic is ADDR_W bits. It cannot wrap because words ≤ MAX_WORDS.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit running XOR covers all DATA bytes; it is cleared on start_i.
  - After the last data byte, state CHK waits for one more valid byte.
  - Byte equal to the running XOR → DONE; otherwise → ERR.
  - Words already written are not rolled back.
- Undefined:
  - CHK state and XOR register are absent; the last data byte goes directly to DONE.
  - Any further bytes are ignored.

Test Plan:
- Basic load: start_i; bytes 02 00 | 78 56 34 12 | EF BE AD DE, one per cycle → writes (0x0000, 0x12345678) and (0x0004, 0xDEADBEEF), each wr_en_o one cycle, 1 cycle after the 4th byte; done_o=1, cpu_hold_o=0, words_o=2.
- Gapped stream: same bytes with random 0–5 idle cycles between valid bytes → identical writes and final state.
- Bad length: header 00 00 → err_o=1, cpu_hold_o=1, no writes. Header 01 10 (4097) → same result. A following start_i clears err_o.
- Reset mid-load: 1 full word plus 2 bytes of the second word, then rst_n=1 for 1 cycle → all outputs 0, state IDLE, no second write. Fresh load then succeeds from address 0.
- Ignored inputs: rx_valid_i bytes while in IDLE produce no writes; start_i during DATA does not restart (words_o keeps counting).
- With PROG_LOADER_CHECKSUM_EN: length 1, word 01 02 04 08, checksum 0x0F → done_o=1. Checksum 0x0E → err_o=1, write at 0x0000 still occurred.
